// File: rtl/router_rx_port.sv
// Receives one router output port: LSB-first serial bits are packed into bytes
// and queued in a first-word-fall-through FIFO with last/err flags.
module router_rx_port #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned PKT_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dout,
    input  logic                 valido_n,
    input  logic                 frameo_n,
    output logic [7:0]           m_data,
    output logic                 m_last,
    output logic                 m_err,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 busy,
    output logic                 overflow,
    output logic                 proto_err,
    input  logic                 clr_flags,
    output logic [PKT_CNT_W-1:0] pkt_count
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RECV, FLUSH} state_t;

    logic                 din_q, vin_n_q, fin_n_q;
    state_t               state_q, state_d;
    logic [7:0]           shifter_q, shifter_d;
    logic [2:0]           bitcnt_q, bitcnt_d;
    logic [7:0]           pend_q, pend_d;
    logic                 pend_v_q, pend_v_d;
    logic                 overflow_q, overflow_d;
    logic                 proto_err_q, proto_err_d;
    logic [PKT_CNT_W-1:0] pkt_count_q, pkt_count_d;

    // FIFO entries are {last, err, data}
    logic [9:0]           mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]          count_q, count_d;

    logic                 take_bit;
    logic                 push;
    logic [9:0]           push_entry;
    logic                 proto_set;
    logic                 pop;
    logic                 full;
    logic                 wr_en;
    logic [9:0]           head;

    always_comb begin
        state_d    = state_q;
        shifter_d  = shifter_q;
        bitcnt_d   = bitcnt_q;
        pend_d     = pend_q;
        pend_v_d   = pend_v_q;
        take_bit   = 1'b0;
        push       = 1'b0;
        push_entry = '0;
        proto_set  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fin_n_q) begin
                    state_d  = RECV;
                    take_bit = !vin_n_q;
                end
            end
            RECV: begin
                take_bit = !vin_n_q;
                if (fin_n_q) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (bitcnt_q != 3'd0) begin
                    push       = 1'b1;
                    push_entry = {2'b11, shifter_q};
                end else if (pend_v_q) begin
                    push       = 1'b1;
                    push_entry = {2'b10, pend_q};
                end
                bitcnt_d  = '0;
                shifter_d = '0;
                pend_v_d  = 1'b0;
                state_d   = IDLE;
                proto_set = !fin_n_q;
            end
            default: state_d = IDLE;
        endcase

        // The shifter is cleared on byte completion so a partial byte is zero-padded.
        if (take_bit) begin
            if (bitcnt_q == 3'd0 && pend_v_q) begin
                push       = 1'b1;
                push_entry = {2'b00, pend_q};
                pend_v_d   = 1'b0;
            end
            if (bitcnt_q == 3'd7) begin
                pend_d    = {din_q, shifter_q[6:0]};
                pend_v_d  = 1'b1;
                shifter_d = '0;
            end else begin
                shifter_d[bitcnt_q] = din_q;
            end
            bitcnt_d = bitcnt_q + 3'd1;
        end
    end

    always_comb begin
        pop      = m_valid && m_ready;
        full     = (count_q == (AW+1)'(DEPTH));
        wr_en    = push && (!full || pop);
        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!wr_en && pop) begin
            count_d = count_q - (AW+1)'(1);
        end

        overflow_d = clr_flags ? 1'b0 : overflow_q;
        if (push && !wr_en) begin
            overflow_d = 1'b1;
        end
        proto_err_d = clr_flags ? 1'b0 : proto_err_q;
        if (proto_set) begin
            proto_err_d = 1'b1;
        end

        pkt_count_d = pkt_count_q;
        if (wr_en && push_entry[9]) begin
            pkt_count_d = pkt_count_q + PKT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            din_q       <= 1'b0;
            vin_n_q     <= 1'b1;
            fin_n_q     <= 1'b1;
            state_q     <= IDLE;
            shifter_q   <= '0;
            bitcnt_q    <= '0;
            pend_q      <= '0;
            pend_v_q    <= 1'b0;
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
            pkt_count_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            din_q       <= dout;
            vin_n_q     <= valido_n;
            fin_n_q     <= frameo_n;
            state_q     <= state_d;
            shifter_q   <= shifter_d;
            bitcnt_q    <= bitcnt_d;
            pend_q      <= pend_d;
            pend_v_q    <= pend_v_d;
            overflow_q  <= overflow_d;
            proto_err_q <= proto_err_d;
            pkt_count_q <= pkt_count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // Head fields are forced to zero while empty so storage needs no reset.
    assign head                     = mem_q[rd_ptr_q];
    assign m_valid                  = (count_q != '0);
    assign {m_last, m_err, m_data}  = m_valid ? head : '0;
    assign busy                     = (state_q != IDLE);
    assign overflow                 = overflow_q;
    assign proto_err                = proto_err_q;
    assign pkt_count                = pkt_count_q;

endmodule

// File: tb/tb_router_rx_port.sv
// Bench for router_rx_port: directed frames plus random frames, checked against
// a frame-level byte model and a capacity-limited expected FIFO.
module tb_router_rx_port;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        dout;
    logic        valido_n;
    logic        frameo_n;
    logic [7:0]  m_data;
    logic        m_last;
    logic        m_err;
    logic        m_valid;
    logic        m_ready;
    logic        busy;
    logic        overflow;
    logic        proto_err;
    logic        clr_flags;
    logic [15:0] pkt_count;

    int          errors = 0;
    int          checks = 0;

    logic [9:0]  exp_q[$];
    int          exp_pkts = 0;
    logic        exp_ovf = 1'b0;
    logic        exp_proto = 1'b0;
    logic        fbits[$];
    int          fgaps[$];
    int          fcyc;

    always #5 clk = ~clk;

    router_rx_port #(.DEPTH(DEPTH), .PKT_CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .dout      (dout),
        .valido_n  (valido_n),
        .frameo_n  (frameo_n),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_err     (m_err),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .busy      (busy),
        .overflow  (overflow),
        .proto_err (proto_err),
        .clr_flags (clr_flags),
        .pkt_count (pkt_count)
    );

    initial begin
        #1ms;
        $display("FAIL watchdog: observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic d, input logic vn, input logic fn);
        dout     = d;
        valido_n = vn;
        frameo_n = fn;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step();
        step(1'($urandom), 1'b1, 1'b1);
    endtask

    // A frame's first sample is consumed one edge after it is pinned, so busy is up by cycle 2.
    task automatic fstep(input logic d, input logic vn, input logic fn);
        step(d, vn, fn);
        fcyc++;
        if (fcyc == 2) chk("busy_mid", 32'(busy), 32'd1);
    endtask

    task automatic add_bits(input logic [7:0] b, input int nb);
        for (int j = 0; j < nb; j++) begin
            fbits.push_back(b[j]);
            fgaps.push_back(0);
        end
    endtask

    task automatic model_frame();
        int n;
        int nb;
        n  = fbits.size();
        nb = (n + 7) / 8;
        for (int k = 0; k < nb; k++) begin
            logic [7:0] b;
            logic       lastf;
            logic       errf;
            b = '0;
            for (int j = 0; j < 8; j++)
                if (k * 8 + j < n) b[j] = fbits[k * 8 + j];
            lastf = (k == nb - 1);
            errf  = lastf && (n % 8 != 0);
            if (exp_q.size() < int'(DEPTH)) begin
                exp_q.push_back({lastf, errf, b});
                if (lastf) exp_pkts++;
            end else begin
                exp_ovf = 1'b1;
            end
        end
    endtask

    task automatic send_frame(input bit end_late, input bit bad_tail, input bit pop_on_flush);
        int       n;
        bit       single;
        logic [9:0] e;
        n      = fbits.size();
        single = (exp_q.size() == 0) && (n > 0) && (n <= 8);
        fcyc   = 0;
        if (n == 0) begin
            fstep(1'($urandom), 1'b1, 1'b0);
            fstep(1'($urandom), 1'b1, 1'b1);
        end else begin
            for (int i = 0; i < n; i++) begin
                if (i == n - 1) begin
                    fstep(fbits[i], 1'b0, end_late ? 1'b0 : 1'b1);
                    if (end_late) begin
                        for (int g = 0; g < fgaps[i]; g++) fstep(1'($urandom), 1'b1, 1'b0);
                        fstep(1'($urandom), 1'b1, 1'b1);
                    end
                end else begin
                    fstep(fbits[i], 1'b0, 1'b0);
                    for (int g = 0; g < fgaps[i]; g++) fstep(1'($urandom), 1'b1, 1'b0);
                end
            end
        end
        if (bad_tail) step(1'b1, 1'b0, 1'b0);
        else          idle_step();
        chk("busy_flush", 32'(busy), 32'd1);
        if (single) chk("flush_early", 32'(m_valid), 32'd0);
        if (pop_on_flush) begin
            e = exp_q.pop_front();
            chk("full_head", 32'({m_last, m_err, m_data}), 32'(e));
            m_ready = 1'b1;
        end
        idle_step();
        m_ready = 1'b0;
        chk("busy_end", 32'(busy), 32'd0);
        if (single) begin
            chk("flush_valid", 32'(m_valid), 32'd1);
            chk("flush_last", 32'(m_last), 32'd1);
        end
        idle_step();
        model_frame();
        if (bad_tail) exp_proto = 1'b1;
        fbits.delete();
        fgaps.delete();
    endtask

    task automatic frame_status(input string tag);
        chk({tag, "_pkt"}, 32'(pkt_count), 32'(exp_pkts % 65536));
        chk({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
        chk({tag, "_proto"}, 32'(proto_err), 32'(exp_proto));
    endtask

    task automatic drain(input string tag, input bit rand_ready);
        int         budget;
        logic [9:0] e;
        budget = 300;
        while (exp_q.size() > 0 && budget > 0) begin
            m_ready = rand_ready ? 1'($urandom) : 1'b1;
            if (m_valid && m_ready) begin
                e = exp_q.pop_front();
                chk({tag, "_entry"}, 32'({m_last, m_err, m_data}), 32'(e));
            end
            @(posedge clk);
            #1;
            budget--;
        end
        m_ready = 1'b0;
        chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_empty"}, 32'(m_valid), 32'd0);
        exp_q.delete();
    endtask

    task automatic clear_flags(input string tag);
        clr_flags = 1'b1;
        idle_step();
        clr_flags = 1'b0;
        exp_ovf   = 1'b0;
        exp_proto = 1'b0;
        chk({tag, "_ovf"}, 32'(overflow), 32'd0);
        chk({tag, "_proto"}, 32'(proto_err), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_data"}, 32'(m_data), 32'd0);
        chk({tag, "_last"}, 32'(m_last), 32'd0);
        chk({tag, "_err"}, 32'(m_err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ovf"}, 32'(overflow), 32'd0);
        chk({tag, "_proto"}, 32'(proto_err), 32'd0);
        chk({tag, "_pkt"}, 32'(pkt_count), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        dout      = 1'b0;
        valido_n  = 1'b1;
        frameo_n  = 1'b1;
        m_ready   = 1'b0;
        clr_flags = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("por");
        reset = 1'b0;
        repeat (2) idle_step();

        // Two full bytes, frameo_n rising with the last bit
        add_bits(8'hA5, 8);
        add_bits(8'h3C, 8);
        send_frame(1'b0, 1'b0, 1'b0);
        frame_status("two_bytes");
        drain("two_bytes", 1'b0);

        // Same frame with idle gaps after bits 2 and 9
        add_bits(8'hA5, 8);
        add_bits(8'h3C, 8);
        fgaps[1] = 3;
        fgaps[8] = 3;
        send_frame(1'b0, 1'b0, 1'b0);
        frame_status("gaps");
        drain("gaps", 1'b0);

        // 11-bit frame ending mid-byte
        add_bits(8'hFF, 8);
        add_bits(8'h05, 3);
        send_frame(1'b0, 1'b0, 1'b0);
        frame_status("partial");
        drain("partial", 1'b0);

        // Frame ends on a non-valid sample after exactly 8 bits
        add_bits(8'h81, 8);
        send_frame(1'b1, 1'b0, 1'b0);
        frame_status("late_end");
        drain("late_end", 1'b0);

        // Empty frame produces nothing
        send_frame(1'b0, 1'b0, 1'b0);
        frame_status("empty");
        drain("empty", 1'b0);

        // Six bytes into a 4-deep FIFO with no consumer
        for (int k = 0; k < 6; k++) add_bits(8'(8'h11 * (k + 1)), 8);
        send_frame(1'b0, 1'b0, 1'b0);
        frame_status("ovf");
        clear_flags("ovf_clr");
        drain("ovf", 1'b0);

        // Full FIFO accepting a push on a same-cycle pop, with a frame start on the flush sample
        for (int k = 0; k < 4; k++) add_bits(8'(8'hC0 + k), 8);
        send_frame(1'b0, 1'b0, 1'b0);
        frame_status("fill");
        add_bits(8'h6E, 8);
        send_frame(1'b0, 1'b1, 1'b1);
        frame_status("full_pop");
        clear_flags("proto_clr");
        drain("full_pop", 1'b0);

        // Reset in the middle of a frame with data still queued
        add_bits(8'h5A, 8);
        send_frame(1'b0, 1'b0, 1'b0);
        frame_status("pre_rst");
        for (int i = 0; i < 5; i++) step(1'(i % 2), 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("rst_async");
        dout     = 1'b0;
        valido_n = 1'b1;
        frameo_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all_zero("rst_hold");
        reset = 1'b0;
        exp_q.delete();
        exp_pkts  = 0;
        exp_ovf   = 1'b0;
        exp_proto = 1'b0;
        repeat (2) idle_step();
        add_bits(8'h3C, 8);
        send_frame(1'b0, 1'b0, 1'b0);
        frame_status("post_rst");
        drain("post_rst", 1'b0);

        // Random frames of 0..32 bits with random gaps, end styles and consumer stalls
        for (int f = 0; f < 25; f++) begin
            int n;
            bit late;
            n = $urandom_range(0, 32);
            for (int i = 0; i < n; i++) begin
                fbits.push_back(1'($urandom));
                fgaps.push_back(($urandom % 4 == 0) ? int'($urandom_range(1, 2)) : 0);
            end
            late = (n <= 1) ? 1'b1 : 1'($urandom);
            send_frame(late, 1'b0, 1'b0);
            frame_status("rnd");
            drain("rnd", 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
